reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised register file for the processor datapath, the successor to the fixed 32×32 register bank. Data width and register count are configurable. It has two registered read ports, one write port with an explicit enable, and a hardwired zero register. A clear sequencer zeroes the whole file on request, one entry per cycle, without asserting reset. The decode stage reads operands from this block and the writeback stage writes results into it.

## Interface
- DATA_W, 32, width of each register and of the data ports
- NUM_REGS, 32, number of registers (≥2)
- ADDR_W, $clog2(NUM_REGS), width of the register-address ports
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes

- Clock  input  1  single clock; all state changes on posedge
- Reset  input  1  asynchronous, active-high; clears all state
- Read_Register1  input  ADDR_W  address for read port 1
- Read_Register2  input  ADDR_W  address for read port 2
- Write_Enable  input  1  write strobe
- Write_Register  input  ADDR_W  write address
- Write_Data  input  DATA_W  write data
- Clear  input  1  one-cycle request to zero all registers
- Read_Data1  output  DATA_W  registered read data, port 1
- Read_Data2  output  DATA_W  registered read data, port 2
- Busy  output  1  high while the clear sweep runs

## Operation
- Reset (asynchronous): all registers, Read_Data1/2, Busy and the sweep counter go to 0. State goes to IDLE.
- Write: performed at posedge when all of the following hold:
  - Write_Enable = 1
  - state = IDLE
  - Clear = 0
  - Write_Register < NUM_REGS
  - not (ZERO_REG = 1 and Write_Register = 0)
- Any write that fails these conditions is silently dropped.
- Read: at every posedge, Read_DataN is loaded with the content of the addressed register, including during a sweep.
  - An address ≥ NUM_REGS reads 0.
  - Register 0 reads 0 when ZERO_REG = 1.
- Clear FSM:
  - IDLE → SWEEP on posedge with Clear = 1. The sweep counter is loaded with 0.
  - In SWEEP, each posedge zeroes register[counter] and increments the counter.
  - SWEEP → IDLE on the posedge that zeroes register NUM_REGS−1. The counter wraps to 0.
  - Clear while in SWEEP is ignored; the sweep is not restarted.
- Busy = 1 exactly when state = SWEEP.
- Clear and Write_Enable asserted in the same IDLE cycle: Clear wins and the write is dropped.
- Reset asserted mid-sweep: aborts immediately. Result is IDLE, Busy = 0, all registers 0.

## Timing
- Read latency is 1 cycle. Addresses presented before posedge k appear on Read_DataN after edge k.
- A write accepted at edge k is visible to reads sampled at edge k+1 and later. Same-edge behaviour depends on the configuration below.
- Clear sampled at edge k:
  - Busy is high after edge k.
  - Edges k+1 … k+NUM_REGS zero registers 0 … NUM_REGS−1.
  - Busy is low after edge k+NUM_REGS.
  - The first write can be accepted at edge k+NUM_REGS+1.
- During a sweep, a read of register i returns 0 if i has already been swept, otherwise its old value.

## Configuration
- REG_FILE_BYPASS_EN defined: write-first forwarding. When a write is accepted at edge k and Read_RegisterN equals Write_Register, Read_DataN after edge k equals Write_Data.
- REG_FILE_BYPASS_EN undefined: read-first. In that case Read_DataN after edge k holds the pre-write value.
- Dropped writes are never forwarded. This includes writes to the zero register, out-of-range writes and writes during a sweep.

## Structure
- Shared package/header reg_file_pkg holds:
  - state encodings IDLE = 1'b0, SWEEP = 1'b1
  - default DATA_W/NUM_REGS constants, shared with the decode and writeback stages
- Sub-module reg_file_clear_seq contains the FSM and sweep counter. Its outputs are Busy, the sweep address and the sweep write strobe. The top level muxes the sweep strobe against the normal write path.

## Test plan
- Reset, then read addresses 0..31 → every Read_Data = 0 and Busy = 0.
- Write 0xDEADBEEF to r5 at edge k, then read r5 at edge k+1 → 0xDEADBEEF. Write 0x1234 to r0, then read r0 → 0 (ZERO_REG = 1).
- Write 0xA5A5A5A5 to r7 while Read_Register1 = 7 on the same edge:
  - with REG_FILE_BYPASS_EN → Read_Data1 = 0xA5A5A5A5
  - without it → old value 0, then 0xA5A5A5A5 one cycle later
- Fill r1..r31 with their index, then pulse Clear:
  - Busy is high for exactly 32 cycles.
  - A write to r3 during the sweep is dropped.
  - Afterwards, all reads return 0.
- Clear and a write to r9 = 0x55 on the same edge → the write is dropped and r9 reads 0 after the sweep. A second Clear mid-sweep does not extend Busy beyond 32 cycles.
- Assert Reset asynchronously in the middle of a sweep → Busy drops without a clock edge, Read_Data = 0, and a write accepted after release works normally.

Source files
------------

// File: rtl/reg_file_pkg.sv
// =============================================================================
// reg_file_pkg : shared constants and state encoding for reg_file_param
// Rev 1.0
// =============================================================================
`default_nettype none

package reg_file_pkg;

    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_clear_seq.sv
// =============================================================================
// reg_file_clear_seq : clear FSM, walks the sweep counter over every register
// Rev 1.0
// =============================================================================
`default_nettype none

module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] count;
    logic [ADDR_W-1:0] count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Clear requests during a sweep are ignored so the sweep never restarts.
    always_comb begin
        state_next = state;
        count_next = count;
        busy       = 1'b0;
        sweep_we   = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_next = SWEEP;
                    count_next = '0;
                end
            end
            SWEEP: begin
                busy     = 1'b1;
                sweep_we = 1'b1;
                if (count == LAST_ADDR) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign sweep_addr = count;

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
// =============================================================================
// reg_file_param : parametrised register file, 2 registered read ports, 1 write
// port, optional hardwired zero register and a clear sweep.
// Optional feature macro: REG_FILE_BYPASS_EN (write-first forwarding).
// Rev 1.0
// =============================================================================
`default_nettype none

module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Read_Register1,
    input  logic [ADDR_W-1:0] Read_Register2,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Write_Register,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Clear,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic              Busy
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              busy;
    logic [ADDR_W-1:0] sweep_addr;
    logic              sweep_we;
    logic              write_ok;
    logic [DATA_W-1:0] rd1_next;
    logic [DATA_W-1:0] rd2_next;

    function automatic logic readable(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < REG_LIMIT) && !(ZERO_REG && (a == '0));
    endfunction

    reg_file_clear_seq #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_seq (
        .clk        (Clock),
        .rst        (Reset),
        .clear      (Clear),
        .busy       (busy),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we)
    );

    assign Busy = busy;

    // Clear beats a same-cycle write; the zero register and out-of-range
    // addresses are never written, which also keeps them out of forwarding.
    always_comb begin
        write_ok = Write_Enable && !busy && !Clear && readable(Write_Register);
    end

    always_comb begin
        rd1_next = '0;
        rd2_next = '0;
        if (readable(Read_Register1)) begin
            rd1_next = regs[Read_Register1];
        end
        if (readable(Read_Register2)) begin
            rd2_next = regs[Read_Register2];
        end
`ifdef REG_FILE_BYPASS_EN
        if (write_ok && (Read_Register1 == Write_Register)) begin
            rd1_next = Write_Data;
        end
        if (write_ok && (Read_Register2 == Write_Register)) begin
            rd2_next = Write_Data;
        end
`endif
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            Read_Data1 <= '0;
            Read_Data2 <= '0;
        end else begin
            if (sweep_we) begin
                regs[sweep_addr] <= '0;
            end else if (write_ok) begin
                regs[Write_Register] <= Write_Data;
            end
            Read_Data1 <= rd1_next;
            Read_Data2 <= rd2_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// =============================================================================
// tb_reg_file_param : directed self-checking bench for reg_file_param
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_reg_file_param;

    logic        clk;
    logic        rst;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        clr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int busy_cycles;

    reg_file_param dut (
        .Clock          (clk),
        .Reset          (rst),
        .Read_Register1 (rr1),
        .Read_Register2 (rr2),
        .Write_Enable   (we),
        .Write_Register (wr),
        .Write_Data     (wd),
        .Clear          (clr),
        .Read_Data1     (rd1),
        .Read_Data2     (rd2),
        .Busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rr1 = '0; rr2 = '0; we = 1'b0; wr = '0; wd = '0; clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd1", rd1, 32'd0);

        // All registers read zero after reset
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            step();
            check("reset_read1", rd1, 32'd0);
            check("reset_read2", rd2, 32'd0);
        end

        // Plain write then read
        we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
        step();
        we = 1'b0; rr1 = 5'd5;
        step();
        check("write_r5", rd1, 32'hDEADBEEF);

        // Zero register ignores writes
        we = 1'b1; wr = 5'd0; wd = 32'h1234;
        rr2 = 5'd0;
        step();
        we = 1'b0; rr1 = 5'd0;
        step();
        check("zero_reg_rd1", rd1, 32'd0);
        check("zero_reg_rd2", rd2, 32'd0);

        // Same-edge read/write of r7
        rr1 = 5'd7; we = 1'b1; wr = 5'd7; wd = 32'hA5A5A5A5;
        step();
`ifdef REG_FILE_BYPASS_EN
        check("same_edge_r7", rd1, 32'hA5A5A5A5);
`else
        check("same_edge_r7", rd1, 32'd0);
`endif
        we = 1'b0;
        step();
        check("next_edge_r7", rd1, 32'hA5A5A5A5);

        // Fill r1..r31 with their index
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wr = 5'(i); wd = 32'(i);
            step();
        end
        we = 1'b0;
        rr1 = 5'd31;
        step();
        check("fill_r31", rd1, 32'd31);

        // Clear sweep with a late write to r3 and reads mid-sweep
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("sweep_busy_start", 32'(busy), 32'd1);
        busy_cycles = 1;
        for (int j = 1; j <= 40; j++) begin
            we = (j == 10); wr = 5'd3; wd = 32'hFFFFFFFF;
            rr1 = 5'd2; rr2 = 5'd20;
            step();
            if (j == 1) check("sweep_unswept_r20", rd2, 32'd20);
            if (j == 5) check("sweep_swept_r2", rd1, 32'd0);
            if (busy) busy_cycles++;
            else break;
        end
        we = 1'b0;
        check("sweep_busy_len", 32'(busy_cycles), 32'd32);
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(i);
            step();
            check("post_sweep_rd1", rd1, 32'd0);
            check("post_sweep_rd2", rd2, 32'd0);
        end

        // Clear and write r9 together, second Clear mid-sweep
        rr1 = 5'd9;
        clr = 1'b1; we = 1'b1; wr = 5'd9; wd = 32'h55;
        step();
        clr = 1'b0; we = 1'b0;
        check("clear_wins_fwd", rd1, 32'd0);
        busy_cycles = 1;
        for (int j = 1; j <= 40; j++) begin
            clr = (j == 10);
            step();
            if (j == 1) check("clear_wins_r9", rd1, 32'd0);
            if (busy) busy_cycles++;
            else break;
        end
        clr = 1'b0;
        check("reclear_busy_len", 32'(busy_cycles), 32'd32);
        step();
        check("after_sweep_r9", rd1, 32'd0);

        // Asynchronous reset in the middle of a sweep
        we = 1'b1; wr = 5'd4; wd = 32'h77;
        step();
        we = 1'b0; rr1 = 5'd4;
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        step();
        check("pre_reset_r4", rd1, 32'h77);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_rd1", rd1, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("after_reset_r4", rd1, 32'd0);
        check("after_reset_busy", 32'(busy), 32'd0);
        we = 1'b1; wr = 5'd6; wd = 32'hCAFE;
        step();
        we = 1'b0; rr2 = 5'd6;
        step();
        check("after_reset_write", rd2, 32'hCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
